// File: rtl/sig_monitor_if.sv
// Signal bundle between the intersection light driver and the conflict monitor.
// The master side drives the light codes; the slave side is the monitor.
interface sig_monitor_if;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_en;
    logic [7:0] phase_cnt;

    modport master (
        output hwy, cntry,
        input  fault, fault_code, flash_en, phase_cnt
    );

    modport slave (
        input  hwy, cntry,
        output fault, fault_code, flash_en, phase_cnt
    );
endinterface

// File: rtl/sig_monitor.sv
// Conflict monitor for the highway/country intersection: checks each light sample
// against the legal sequence and dwell limits, latching the first violation.
module sig_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MIN_ALLRED = 2
) (
    input logic          clock,
    input logic          clear,
    sig_monitor_if.slave bus
);
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] BAD    = 2'd3;

    typedef enum logic [1:0] {INIT, MONITOR, FAULT} state_t;

    state_t     state;
    logic [1:0] hwy_p1;
    logic [1:0] cntry_p1;
    logic [7:0] hwy_ycnt;
    logic [7:0] cntry_ycnt;
    logic [7:0] allred_cnt;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] phase_cnt;
    logic [2:0] viol;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic bad_step(input logic [1:0] p, input logic [1:0] n);
        return (p == GREEN && n == RED) || (p == RED && n == YELLOW) ||
               (p == YELLOW && n == GREEN);
    endfunction

    function automatic logic short_yellow(input logic [1:0] p, input logic [1:0] n,
                                          input logic [7:0] cnt);
        return (p == YELLOW) && (n == RED) && (int'(cnt) < MIN_YELLOW);
    endfunction

    // Dwell count of the sample just taken: 1 on entry, saturating while held.
    function automatic logic [7:0] next_ycnt(input logic [1:0] p, input logic [1:0] n,
                                             input logic [7:0] cnt);
        if (n != YELLOW) return 8'd0;
        if (p == YELLOW) return sat_inc(cnt);
        return 8'd1;
    endfunction

    always_comb begin
        viol = 3'd0;
        if (bus.hwy == BAD || bus.cntry == BAD)
            viol = 3'd1;
        else if (bus.hwy != RED && bus.cntry != RED)
            viol = 3'd2;
        else if (bad_step(hwy_p1, bus.hwy) || bad_step(cntry_p1, bus.cntry))
            viol = 3'd3;
        else if (short_yellow(hwy_p1, bus.hwy, hwy_ycnt) ||
                 short_yellow(cntry_p1, bus.cntry, cntry_ycnt))
            viol = 3'd4;
        else if (((hwy_p1 == RED && bus.hwy == GREEN) ||
                  (cntry_p1 == RED && bus.cntry == GREEN)) &&
                 (int'(allred_cnt) < MIN_ALLRED))
            viol = 3'd5;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= INIT;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            phase_cnt  <= 8'd0;
            hwy_ycnt   <= 8'd0;
            cntry_ycnt <= 8'd0;
            allred_cnt <= 8'd0;
            hwy_p1     <= RED;
            cntry_p1   <= RED;
        end else begin
            if (state != FAULT) begin
                hwy_p1     <= bus.hwy;
                cntry_p1   <= bus.cntry;
                hwy_ycnt   <= next_ycnt(hwy_p1, bus.hwy, hwy_ycnt);
                cntry_ycnt <= next_ycnt(cntry_p1, bus.cntry, cntry_ycnt);
                allred_cnt <= (bus.hwy == RED && bus.cntry == RED) ? sat_inc(allred_cnt) : 8'd0;
            end
            case (state)
                INIT: state <= MONITOR;
                MONITOR: begin
                    if (viol != 3'd0) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= viol;
                    end else if (cntry_p1 == YELLOW && bus.cntry == RED) begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                default: state <= FAULT;
            endcase
        end
    end

    assign bus.fault      = fault;
    assign bus.flash_en   = fault;
    assign bus.fault_code = fault_code;
    assign bus.phase_cnt  = phase_cnt;
endmodule

// File: tb/tb_sig_monitor.sv
// Bench for sig_monitor: a history-based reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_sig_monitor;
    localparam int MIN_YELLOW = 3;
    localparam int MIN_ALLRED = 2;
    localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2, X = 2'd3;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sig_monitor_if bus();

    sig_monitor #(.MIN_YELLOW(MIN_YELLOW), .MIN_ALLRED(MIN_ALLRED)) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the full sample history since the last clear.
    logic [1:0] hist_h[$];
    logic [1:0] hist_c[$];
    bit         m_fault   = 1'b0;
    int         m_code    = 0;
    int         m_phase   = 0;
    bit         started   = 1'b0;

    function automatic int trail_yellow(input bit country);
        int n = 0;
        for (int i = hist_h.size() - 1; i >= 0; i--) begin
            if ((country ? hist_c[i] : hist_h[i]) != Y) break;
            n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int trail_allred();
        int n = 0;
        for (int i = hist_h.size() - 1; i >= 0; i--) begin
            if (hist_h[i] != R || hist_c[i] != R) break;
            n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic bit illegal_step(input logic [1:0] p, input logic [1:0] n);
        return (p == G && n == R) || (p == R && n == Y) || (p == Y && n == G);
    endfunction

    function automatic int violation(input logic [1:0] h, input logic [1:0] c);
        logic [1:0] ph = hist_h[hist_h.size() - 1];
        logic [1:0] pc = hist_c[hist_c.size() - 1];
        if (h == X || c == X) return 1;
        if (h != R && c != R) return 2;
        if (illegal_step(ph, h) || illegal_step(pc, c)) return 3;
        if ((ph == Y && h == R && trail_yellow(1'b0) < MIN_YELLOW) ||
            (pc == Y && c == R && trail_yellow(1'b1) < MIN_YELLOW)) return 4;
        if (((ph == R && h == G) || (pc == R && c == G)) && trail_allred() < MIN_ALLRED) return 5;
        return 0;
    endfunction

    always @(posedge clock) begin
        int code_now;
        started = 1'b1;
        if (clear) begin
            hist_h.delete();
            hist_c.delete();
            m_fault = 1'b0;
            m_code  = 0;
            m_phase = 0;
        end else begin
            if (hist_h.size() != 0 && !m_fault) begin
                code_now = violation(bus.hwy, bus.cntry);
                if (code_now != 0) begin
                    m_fault = 1'b1;
                    m_code  = code_now;
                end else if (hist_c[hist_c.size() - 1] == Y && bus.cntry == R && m_phase < 255) begin
                    m_phase++;
                end
            end
            hist_h.push_back(bus.hwy);
            hist_c.push_back(bus.cntry);
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("fault", bus.fault, m_fault);
            check("flash_en", bus.flash_en, m_fault);
            check("fault_code", bus.fault_code, m_code);
            check("phase_cnt", bus.phase_cnt, m_phase);
        end
    end

    task automatic drive(input logic [1:0] h, input logic [1:0] c);
        bus.hwy   = h;
        bus.cntry = c;
        @(posedge clock);
        #2;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock);
        #2;
        clear = 1'b0;
    endtask

    task automatic expect_out(input string name, input int f, input int code, input int ph);
        check({name, "_fault"}, bus.fault, f);
        check({name, "_flash"}, bus.flash_en, f);
        check({name, "_code"}, bus.fault_code, code);
        check({name, "_phase"}, bus.phase_cnt, ph);
        check({name, "_model_code"}, m_code, code);
    endtask

    initial begin
        bus.hwy   = R;
        bus.cntry = R;
        repeat (2) @(posedge clock);
        #2;
        expect_out("reset", 0, 0, 0);
        clear = 1'b0;

        // Three complete signal cycles, with a long highway hold in the first.
        for (int k = 0; k < 3; k++) begin
            repeat (k == 0 ? 20 : 4) drive(G, R);
            repeat (3) drive(Y, R);
            repeat (2) drive(R, R);
            repeat (4) drive(R, G);
            repeat (3) drive(R, Y);
            repeat (2) drive(R, R);
        end
        expect_out("normal", 0, 0, 3);
        check("normal_model_phase", m_phase, 3);

        drive(G, G);
        expect_out("conflict", 1, 2, 3);
        drive(R, R);
        drive(G, R);
        drive(X, X);
        expect_out("conflict_hold", 1, 2, 3);

        do_clear();
        expect_out("clear_in_fault", 0, 0, 0);
        drive(G, R);
        drive(G, R);
        drive(R, R);
        expect_out("green_to_red", 1, 3, 0);

        do_clear();
        drive(R, R);
        drive(X, Y);
        expect_out("priority", 1, 1, 0);

        do_clear();
        drive(G, R);
        drive(G, R);
        repeat (2) drive(Y, R);
        expect_out("yellow2_before", 0, 0, 0);
        drive(R, R);
        expect_out("short_yellow", 1, 4, 0);

        do_clear();
        drive(G, R);
        drive(G, R);
        repeat (3) drive(Y, R);
        drive(R, R);
        expect_out("yellow3_ok", 0, 0, 0);

        do_clear();
        drive(G, R);
        repeat (3) drive(Y, R);
        drive(R, R);
        drive(R, G);
        expect_out("short_clear", 1, 5, 0);

        do_clear();
        drive(G, R);
        repeat (3) drive(Y, R);
        repeat (2) drive(R, R);
        drive(R, G);
        expect_out("clear_ok", 0, 0, 0);

        // Yellow on the INIT sample looks like RED->YELLOW but is unchecked.
        do_clear();
        drive(Y, R);
        expect_out("init_unchecked", 0, 0, 0);
        repeat (2) drive(Y, R);
        drive(R, R);
        expect_out("init_yellow_dwell", 0, 0, 0);

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
